audio_i2s_receiver: RTL

- Deserialises the codec ADC I2S stream (BCLK, ADCLRCK, ADCDAT) into 32-bit stereo words {left[31:16], right[15:0]}, signed two's complement.
- Sits directly upstream of the LED level visualiser and the audio filter chain.
- All codec inputs are oversampled in the `clk` domain; no codec clock is used as a clock.

---
 rtl/audio_i2s_receiver_pkg.sv | 20 ++
 rtl/audio_i2s_receiver_sync_edge_detect.sv | 31 +++
 rtl/audio_i2s_receiver.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/audio_i2s_receiver_pkg.sv
// Shared audio constants: sample/stereo widths, half-word bit positions and
// the receiver FSM state encoding.
package audio_i2s_receiver_pkg;

    localparam int SAMPLE_W  = 16;
    localparam int STEREO_W  = 32;
    localparam int LEFT_MSB  = 31;
    localparam int LEFT_LSB  = 16;
    localparam int RIGHT_MSB = 15;
    localparam int RIGHT_LSB = 0;

    typedef enum logic [2:0] {
        SYNC    = 3'd0,
        SKIP_L  = 3'd1,
        SHIFT_L = 3'd2,
        SKIP_R  = 3'd3,
        SHIFT_R = 3'd4
    } state_t;

endpackage

// File: rtl/audio_i2s_receiver_sync_edge_detect.sv
// Multi-flop synchroniser for one asynchronous input, plus a history flop
// giving single-cycle rise/fall strobes in the clk domain.
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
            hist  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            hist  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~hist;
    assign fall  = ~level & hist;

endmodule

// File: rtl/audio_i2s_receiver.sv
// I2S ADC deserialiser: oversamples BCLK/ADCLRCK/ADCDAT in the clk domain and
// emits 32-bit {left, right} frames, flagging channels that end short.
module audio_i2s_receiver
    import audio_i2s_receiver_pkg::*;
#(
    parameter int SAMPLE_BITS = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                bclk_in,
    input  logic                adclrck_in,
    input  logic                adcdat_in,
    output logic [STEREO_W-1:0] sample_out,
    output logic                sample_valid,
    output logic                frame_error
);

    localparam logic [4:0] CNT_FULL = 5'(SAMPLE_BITS);

    logic bclk_rise, bclk_level_unused, bclk_fall_unused;
    logic lrck_rise, lrck_fall, lrck_level_unused;
    logic dat, dat_rise_unused, dat_fall_unused;

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_bclk (
        .clk   (clk),
        .rst   (rst),
        .din   (bclk_in),
        .level (bclk_level_unused),
        .rise  (bclk_rise),
        .fall  (bclk_fall_unused)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_lrck (
        .clk   (clk),
        .rst   (rst),
        .din   (adclrck_in),
        .level (lrck_level_unused),
        .rise  (lrck_rise),
        .fall  (lrck_fall)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES)) u_dat (
        .clk   (clk),
        .rst   (rst),
        .din   (adcdat_in),
        .level (dat),
        .rise  (dat_rise_unused),
        .fall  (dat_fall_unused)
    );

    state_t              state, state_n;
    logic [4:0]          cnt;
    logic [SAMPLE_W-1:0] shreg;
    logic [SAMPLE_W-1:0] left_hold;
    logic                discard, discard_n;
    logic                start_ch, shift_en, latch_left, emit, err;
    logic                short_ch;
    logic [3:0]          bit_idx;

    assign short_ch = (cnt < CNT_FULL);
    // MSB-first capture straight into its final bit, so narrow samples land left-aligned.
    assign bit_idx  = 4'(SAMPLE_W - 1) - cnt[3:0];

    always_comb begin
        state_n    = state;
        discard_n  = discard;
        start_ch   = 1'b0;
        shift_en   = 1'b0;
        latch_left = 1'b0;
        emit       = 1'b0;
        err        = 1'b0;
        case (state)
            SYNC: begin
                discard_n = 1'b0;
                if (lrck_fall) begin
                    start_ch = bclk_rise;
                    state_n  = bclk_rise ? SHIFT_L : SKIP_L;
                end
            end
            SKIP_L, SHIFT_L: begin
                // LRCK edge wins over a coincident BCLK rise, which then acts as the skip bit.
                if (lrck_rise) begin
                    if (state == SKIP_L || short_ch) begin
                        err       = 1'b1;
                        discard_n = 1'b1;
                    end else begin
                        latch_left = 1'b1;
                        discard_n  = 1'b0;
                    end
                    start_ch = bclk_rise;
                    state_n  = bclk_rise ? SHIFT_R : SKIP_R;
                end else if (bclk_rise) begin
                    if (state == SKIP_L) begin
                        start_ch = 1'b1;
                        state_n  = SHIFT_L;
                    end else if (short_ch) begin
                        shift_en = 1'b1;
                    end
                end
            end
            SKIP_R, SHIFT_R: begin
                if (lrck_fall) begin
                    if (state == SKIP_R || short_ch) begin
                        err = 1'b1;
                    end else if (!discard) begin
                        emit = 1'b1;
                    end
                    discard_n = 1'b0;
                    start_ch  = bclk_rise;
                    state_n   = bclk_rise ? SHIFT_L : SKIP_L;
                end else if (bclk_rise) begin
                    if (state == SKIP_R) begin
                        start_ch = 1'b1;
                        state_n  = SHIFT_R;
                    end else if (short_ch) begin
                        shift_en = 1'b1;
                    end
                end
            end
            default: state_n = SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= SYNC;
            discard      <= 1'b0;
            cnt          <= '0;
            shreg        <= '0;
            left_hold    <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            state        <= state_n;
            discard      <= discard_n;
            sample_valid <= emit;
            frame_error  <= err;
            if (start_ch) begin
                cnt   <= '0;
                shreg <= '0;
            end else if (shift_en) begin
                shreg[bit_idx] <= dat;
                cnt            <= cnt + 5'd1;
            end
            if (latch_left) left_hold <= shreg;
            if (emit) begin
                sample_out[LEFT_MSB:LEFT_LSB]   <= left_hold;
                sample_out[RIGHT_MSB:RIGHT_LSB] <= shreg;
            end
        end
    end

endmodule
